// File: rtl/fp_sub_ieee754_seq.sv
// fp_sub_ieee754_seq: multi-cycle IEEE-754 single-precision subtractor, result = a - b.
// Small-area companion to the combinational float adder: it aligns, adds or subtracts
// and handles the carry in fixed cycles, then normalizes one bit per cycle.
// Truncating rounding. Denormal inputs are flushed to zero. Any NaN or Inf input
// gives the quiet NaN 0x7FC00000.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake; in_ready is high only in IDLE
//   a, b                  minuend and subtrahend
//   out_valid / out_ready result handshake; result stays stable while out_valid is high
//   result                a - b
//   busy                  high whenever the block is not in IDLE
module fp_sub_ieee754_seq #(
  parameter int WIDTH = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int               DW      = MAN_W + 2;  // carry + hidden + fraction
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic [EXP_W-1:0] DW_E    = EXP_W'(DW);
  localparam logic [WIDTH-1:0] QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             sx_q, sx_d, sub_q, sub_d, fin_q, fin_d;
  logic [EXP_W-1:0] ex_q, ex_d;
  logic [DW-1:0]    mx_q, mx_d, my_q, my_d;

  // Unpacked operands and the adder output.
  logic [EXP_W-1:0] ea, eb, diff;
  logic [DW-1:0]    ma, mb, sml, sum;
  logic             sa, sb, a_big;

  always_comb begin
    ea    = a_q[WIDTH-2 -: EXP_W];
    eb    = b_q[WIDTH-2 -: EXP_W];
    ma    = (ea == '0) ? '0 : {2'b01, a_q[MAN_W-1:0]};
    mb    = (eb == '0) ? '0 : {2'b01, b_q[MAN_W-1:0]};
    sa    = a_q[WIDTH-1];
    sb    = ~b_q[WIDTH-1];  // subtracting b means adding -b
    a_big = {ea, ma[MAN_W-1:0]} >= {eb, mb[MAN_W-1:0]};
    diff  = a_big ? (ea - eb) : (eb - ea);
    sml   = a_big ? mb : ma;
    // X always has the larger magnitude, so X - smaller never goes negative.
    sum   = sub_q ? (mx_q - my_q) : (mx_q + my_q);
  end

  // Every result leaves through NORM. A result that is already final (NaN, zero
  // or Inf) has fin set and passes through NORM in one cycle. This fixes special
  // results at latency 2 (NaN) or 3 (zero or Inf).
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sx_d    = sx_q;
    sub_d   = sub_q;
    fin_d   = fin_q;
    ex_d    = ex_q;
    mx_d    = mx_q;
    my_d    = my_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        fin_d   = 1'b0;
        state_d = ALIGN;
      end
      ALIGN: begin
        sx_d  = a_big ? sa : sb;
        sub_d = sa ^ sb;
        ex_d  = a_big ? ea : eb;
        mx_d  = a_big ? ma : mb;
        my_d  = (diff >= DW_E) ? '0 : (sml >> diff);
        if (ea == EXP_MAX || eb == EXP_MAX) begin
          res_d   = QNAN;
          fin_d   = 1'b1;
          state_d = NORM;
        end else begin
          state_d = ADD;
        end
      end
      ADD: begin
        state_d = NORM;
        if (sum == '0) begin
          // Exact cancellation gives +0. A zero sum from two zeros keeps the sign.
          res_d = sub_q ? '0 : {sx_q, {(WIDTH-1){1'b0}}};
          fin_d = 1'b1;
        end else if (sum[DW-1]) begin
          mx_d = sum >> 1;
          ex_d = ex_q + 1'b1;
          if (ex_q == EXP_MAX - 1'b1) begin
            res_d = {sx_q, EXP_MAX, {MAN_W{1'b0}}};
            fin_d = 1'b1;
          end
        end else begin
          mx_d = sum;
        end
      end
      NORM: begin
        if (fin_q) begin
          state_d = DONE;
        end else if (mx_q[DW-2]) begin
          res_d   = {sx_q, ex_q, mx_q[MAN_W-1:0]};
          state_d = DONE;
        end else if (ex_q == EXP_ONE) begin
          // The value fell below the smallest normal. Flush it to a signed zero.
          res_d   = {sx_q, {(WIDTH-1){1'b0}}};
          state_d = DONE;
        end else begin
          mx_d = mx_q << 1;
          ex_d = ex_q - 1'b1;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sx_q    <= 1'b0;
      sub_q   <= 1'b0;
      fin_q   <= 1'b0;
      ex_q    <= '0;
      mx_q    <= '0;
      my_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sx_q    <= sx_d;
      sub_q   <= sub_d;
      fin_q   <= fin_d;
      ex_q    <= ex_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
endmodule
